ps2_code_lock: RTL and testbench

//  Parametrised keypad-lock FSM in the sys clock domain, after the PS/2 decoder and async FIFO.

---
 rtl/ps2_lock_pkg.sv | 18 +
 rtl/ps2_code_lock_if.sv | 21 ++
 rtl/ps2_code_lock_timer.sv | 27 ++
 rtl/ps2_code_lock.sv | 150 +++++++++++++++
 tb/tb_ps2_code_lock.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_lock_pkg.sv
// Shared types and constants for the PS/2 keypad code lock.
// Lock FSM states, PS/2 prefix bytes and a small max helper.
package ps2_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    UNLOCKED,
    LOCKOUT
  } lock_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_code_lock_if.sv
// FWFT FIFO read port between the scancode FIFO and the lock.
// master = FIFO side (empty, code); slave = lock side (r_en).
interface ps2_code_lock_if #(
  parameter int CODE_WIDTH = 8
);
  logic                  empty;
  logic [CODE_WIDTH-1:0] code;
  logic                  r_en;

  modport master (
    output empty,
    output code,
    input  r_en
  );

  modport slave (
    input  empty,
    input  code,
    output r_en
  );
endinterface

// File: rtl/ps2_code_lock_timer.sv
// Down-counter shared by the unlock hold and the lockout period.
// Ports: clk, rst_n, load, load_val -> expired (count == 0).
module lock_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ps2_code_lock.sv
// Keypad code lock: pops PS/2 scancodes, matches a password, holds unlock, locks out.
// Ports: clk, rst_n, fifo (FWFT read), password, relock -> leds, unlocked, locked_out, fail, attempts_left.
module ps2_code_lock
  import ps2_lock_pkg::*;
#(
  parameter int PASSWORD_LEN   = 4,
  parameter int CODE_WIDTH     = 8,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int UNLOCK_CYCLES  = 50_000_000,
  parameter int LOCKOUT_CYCLES = 100_000_000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  ps2_code_lock_if.slave                     fifo,
  input  logic [PASSWORD_LEN*CODE_WIDTH-1:0] password,
  input  logic                               relock,
  output logic [PASSWORD_LEN-1:0]            leds,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic                               fail,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]  attempts_left
);

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int TW = max_i(1, $clog2(max_i(UNLOCK_CYCLES, LOCKOUT_CYCLES)));
  localparam int IW = max_i(1, $clog2(PASSWORD_LEN));
  localparam int CW = CODE_WIDTH;

  lock_state_t     state;
  logic [IW-1:0]   idx;
  logic            skip;

  logic [CW-1:0]   digit [PASSWORD_LEN];

  logic            take;
  logic            is_ext;
  logic            is_brk;
  logic            real_byte;
  logic            hit;
  logic            last;
  logic            to_lock;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_expired;

  for (genvar i = 0; i < PASSWORD_LEN; i++) begin : g_dig
    assign digit[i] = password[i*CW +: CW];
  end

  // Popping never stalls: bytes in UNLOCKED/LOCKOUT are simply drained.
  assign fifo.r_en = !fifo.empty;

  always_comb begin
    take      = !fifo.empty;
    is_ext    = (fifo.code == CW'(PS2_EXT));
    is_brk    = (fifo.code == CW'(PS2_BREAK));
    real_byte = take && (state == ENTRY) && !skip && !is_ext && !is_brk;
    hit       = (fifo.code == digit[idx]);
    last      = (idx == IW'(PASSWORD_LEN - 1));
    to_lock   = (attempts_left == AW'(1));
    tmr_load  = 1'b0;
    tmr_val   = TW'(UNLOCK_CYCLES - 1);
    if (real_byte && hit && last) begin
      tmr_load = 1'b1;
    end else if (real_byte && !hit && to_lock) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(LOCKOUT_CYCLES - 1);
    end
  end

  lock_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ENTRY;
      idx           <= '0;
      skip          <= 1'b0;
      leds          <= '0;
      unlocked      <= 1'b0;
      locked_out    <= 1'b0;
      fail          <= 1'b0;
      attempts_left <= AW'(MAX_ATTEMPTS);
    end else begin
      fail <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (take) begin
            if (skip) begin
              skip <= 1'b0;
            end else if (is_ext) begin
              skip <= 1'b0;
            end else if (is_brk) begin
              skip <= 1'b1;
            end else if (hit && last) begin
              state         <= UNLOCKED;
              leds          <= '1;
              unlocked      <= 1'b1;
              idx           <= '0;
              attempts_left <= AW'(MAX_ATTEMPTS);
            end else if (hit) begin
              leds[idx] <= 1'b1;
              idx       <= idx + IW'(1);
            end else begin
              leds <= '0;
              idx  <= '0;
              fail <= 1'b1;
              if (to_lock) begin
                state         <= LOCKOUT;
                locked_out    <= 1'b1;
                attempts_left <= '0;
              end else begin
                attempts_left <= attempts_left - AW'(1);
              end
            end
          end
        end
        UNLOCKED: begin
          if (relock || tmr_expired) begin
            state    <= ENTRY;
            leds     <= '0;
            unlocked <= 1'b0;
            idx      <= '0;
            skip     <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (tmr_expired) begin
            state         <= ENTRY;
            locked_out    <= 1'b0;
            attempts_left <= AW'(MAX_ATTEMPTS);
            idx           <= '0;
            skip          <= 1'b0;
          end
        end
        default: begin
          state <= ENTRY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_code_lock.sv
// Self-checking bench for ps2_code_lock.
// Table-driven byte pushes plus directed relock/reset sequences.
module tb_ps2_code_lock;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] password;
  logic        relock;
  logic [3:0]  leds;
  logic        unlocked;
  logic        locked_out;
  logic        fail;
  logic [1:0]  attempts_left;

  int total = 0;
  int bad = 0;
  int fail_cnt = 0;

  ps2_code_lock_if #(.CODE_WIDTH(8)) fif ();

  ps2_code_lock #(
    .PASSWORD_LEN  (4),
    .CODE_WIDTH    (8),
    .MAX_ATTEMPTS  (3),
    .UNLOCK_CYCLES (20),
    .LOCKOUT_CYCLES(50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo         (fif.slave),
    .password     (password),
    .relock       (relock),
    .leds         (leds),
    .unlocked     (unlocked),
    .locked_out   (locked_out),
    .fail         (fail),
    .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  // fail is a one-cycle pulse, so exactly one falling edge sees it.
  always @(negedge clk) begin
    if (fail) fail_cnt++;
  end

  typedef struct {
    bit         push;
    logic [7:0] code;
    int         idle;
    logic [3:0] leds;
    bit         unl;
    bit         lko;
    logic [1:0] att;
    int         fails;
  } vec_t;

  vec_t tv[$];

  task automatic add(bit p, logic [7:0] c, int idl, logic [3:0] l,
                     bit u, bit k, logic [1:0] a, int f);
    vec_t v;
    v.push = p; v.code = c; v.idle = idl; v.leds = l;
    v.unl = u; v.lko = k; v.att = a; v.fails = f;
    tv.push_back(v);
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [3:0] l, bit u, bit k, logic [1:0] a);
    chk({nm, "_leds"}, 32'(leds), 32'(l));
    chk({nm, "_unl"}, 32'(unlocked), 32'(u));
    chk({nm, "_lko"}, 32'(locked_out), 32'(k));
    chk({nm, "_att"}, 32'(attempts_left), 32'(a));
  endtask

  // Called at a falling edge; returns at the falling edge after the pop.
  task automatic push(logic [7:0] c);
    fif.empty = 1'b0;
    fif.code  = c;
    #1;
    chk("r_en_hi", 32'(fif.r_en), 32'd1);
    @(negedge clk);
    fif.empty = 1'b1;
    fif.code  = 8'h00;
    #1;
    chk("r_en_lo", 32'(fif.r_en), 32'd0);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    relock    = 1'b0;
    fif.empty = 1'b1;
    fif.code  = 8'h00;
    password  = {8'h2C, 8'h1B, 8'h24, 8'h2C};

    // correct entry, hold expiry
    add(1, 8'h2C, 1, 4'b0001, 0, 0, 3, 0);
    add(1, 8'h24, 1, 4'b0011, 0, 0, 3, 0);
    add(1, 8'h1B, 1, 4'b0111, 0, 0, 3, 0);
    add(1, 8'h2C, 1, 4'b1111, 1, 0, 3, 0);
    add(0, 8'h00, 18, 4'b1111, 1, 0, 3, 0);
    add(0, 8'h00, 1, 4'b0000, 0, 0, 3, 0);
    // prefix filtering
    add(1, 8'h2C, 1, 4'b0001, 0, 0, 3, 0);
    add(1, 8'hF0, 1, 4'b0001, 0, 0, 3, 0);
    add(1, 8'h2C, 1, 4'b0001, 0, 0, 3, 0);
    add(1, 8'hE0, 1, 4'b0001, 0, 0, 3, 0);
    add(1, 8'h24, 1, 4'b0011, 0, 0, 3, 0);
    add(1, 8'h1B, 1, 4'b0111, 0, 0, 3, 0);
    add(1, 8'h2C, 1, 4'b1111, 1, 0, 3, 0);
    add(0, 8'h00, 19, 4'b0000, 0, 0, 3, 0);
    // one mismatch, then success restores attempts
    add(1, 8'h2C, 1, 4'b0001, 0, 0, 3, 0);
    add(1, 8'h24, 1, 4'b0011, 0, 0, 3, 0);
    add(1, 8'h33, 1, 4'b0000, 0, 0, 2, 1);
    add(1, 8'h2C, 1, 4'b0001, 0, 0, 2, 1);
    add(1, 8'h24, 1, 4'b0011, 0, 0, 2, 1);
    add(1, 8'h1B, 1, 4'b0111, 0, 0, 2, 1);
    add(1, 8'h2C, 1, 4'b1111, 1, 0, 3, 1);
    add(0, 8'h00, 19, 4'b0000, 0, 0, 3, 1);
    // lockout, drained bytes, expiry
    add(1, 8'h33, 1, 4'b0000, 0, 0, 2, 2);
    add(1, 8'h33, 1, 4'b0000, 0, 0, 1, 3);
    add(1, 8'h33, 1, 4'b0000, 0, 1, 0, 4);
    add(1, 8'h2C, 1, 4'b0000, 0, 1, 0, 4);
    add(1, 8'h24, 1, 4'b0000, 0, 1, 0, 4);
    add(1, 8'h1B, 1, 4'b0000, 0, 1, 0, 4);
    add(1, 8'h2C, 1, 4'b0000, 0, 1, 0, 4);
    add(0, 8'h00, 40, 4'b0000, 0, 1, 0, 4);
    add(0, 8'h00, 1, 4'b0000, 0, 0, 3, 4);
    // unlock again for the relock sequence
    add(1, 8'h2C, 1, 4'b0001, 0, 0, 3, 4);
    add(1, 8'h24, 1, 4'b0011, 0, 0, 3, 4);
    add(1, 8'h1B, 1, 4'b0111, 0, 0, 3, 4);
    add(1, 8'h2C, 1, 4'b1111, 1, 0, 3, 4);

    idle(2);
    chk_out("reset", 4'b0000, 0, 0, 3);
    chk("reset_fail", 32'(fail), 32'd0);
    chk("reset_r_en", 32'(fif.r_en), 32'd0);
    rst_n = 1'b1;
    idle(1);

    foreach (tv[i]) begin
      if (tv[i].push) push(tv[i].code);
      idle(tv[i].idle);
      chk_out($sformatf("v%0d", i), tv[i].leds, tv[i].unl, tv[i].lko, tv[i].att);
      chk($sformatf("v%0d_fails", i), 32'(fail_cnt), 32'(tv[i].fails));
    end

    // bytes while unlocked are drained, relock exits at once
    push(8'h2C);
    chk_out("unl_drain1", 4'b1111, 1, 0, 3);
    push(8'h24);
    chk_out("unl_drain2", 4'b1111, 1, 0, 3);
    relock = 1'b1;
    idle(1);
    relock = 1'b0;
    chk_out("relock", 4'b0000, 0, 0, 3);
    push(8'h2C);
    idle(1);
    chk_out("after_relock", 4'b0001, 0, 0, 3);
    chk("after_relock_fails", 32'(fail_cnt), 32'd4);

    // reset mid-sequence with idx=2
    push(8'h24);
    idle(1);
    chk_out("pre_rst", 4'b0011, 0, 0, 3);
    rst_n = 1'b0;
    idle(1);
    chk_out("rst_mid", 4'b0000, 0, 0, 3);
    chk("rst_mid_r_en", 32'(fif.r_en), 32'd0);
    rst_n = 1'b1;
    idle(3);
    chk_out("rst_quiet", 4'b0000, 0, 0, 3);

    // lockout ignores relock, then reset out of it
    push(8'h33); idle(1);
    push(8'h33); idle(1);
    push(8'h33); idle(1);
    chk_out("lock2", 4'b0000, 0, 1, 0);
    chk("lock2_fails", 32'(fail_cnt), 32'd7);
    relock = 1'b1;
    idle(1);
    relock = 1'b0;
    idle(1);
    chk_out("lock_relock", 4'b0000, 0, 1, 0);
    idle(5);
    rst_n = 1'b0;
    idle(1);
    chk_out("rst_lock", 4'b0000, 0, 0, 3);
    chk("rst_lock_fail", 32'(fail), 32'd0);
    rst_n = 1'b1;
    idle(60);
    chk_out("rst_lock_quiet", 4'b0000, 0, 0, 3);
    push(8'h2C);
    idle(1);
    chk_out("post_rst_entry", 4'b0001, 0, 0, 3);
    chk("final_fails", 32'(fail_cnt), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
